rotor_stack_stepper: RTL
========================

// Module: rotor_stack_stepper
// PURPOSE
//  Holds positions and notch settings of a stack of NUM_ROTORI cipher rotors and advances them
//  with stepping and double-stepping on each key press. Sits between the keyboard front end and
//  the rotor substitution path; pozitii_out feeds every rotor_master instance. Initial positions
//  and notches are loaded per rotor through a write port.
// PARAMETERS
//  NUM_ROTORI   3                      number of rotors; rotor 0 is the fast (rightmost) rotor
//  ALFABET      26                     symbols per rotor; positions 0..ALFABET-1
//  POS_W        $clog2(ALFABET)        derived localparam; position/notch width (5)
//  SEL_W        $clog2(NUM_ROTORI)     derived localparam; rotor index width (2)
// PORTS
//  clk                  in   1                    single clock, rising edge
//  rst                  in   1                    asynchronous, active-high reset
//  scrie_in             in   1                    load strobe for one rotor
//  index_rotor_in       in   SEL_W                rotor to load
//  pozitie_initiala_in  in   POS_W                initial position to load
//  crestatura_in        in   POS_W                notch position to load
//  pas_in               in   1                    step request (one key press)
//  pozitii_out          out  NUM_ROTORI*POS_W     rotor i at [i*POS_W +: POS_W]
//  ocupat_out           out  1                    high while a step is in progress
//  pas_gata_out         out  1                    1-cycle pulse: new positions valid
//  eroare_out           out  1                    1-cycle pulse: rejected load
// BEHAVIOUR
//  - Reset (async, any state): all positions 0, all notches ALFABET-1, FSM INACTIV,
//    ocupat_out=0, pas_gata_out=0, eroare_out=0.
//  - FSM states: INACTIV, CALCUL. INACTIV --pas_in & !scrie_in--> CALCUL; CALCUL --> INACTIV
//    unconditionally after one cycle.
//  - Step timing: pas_in sampled high in INACTIV at edge k -> ocupat_out=1 after k.
//    At edge k+1, positions update and pas_gata_out=1 for that one cycle. ocupat_out=0 after k+1.
//  - pas_in is ignored while in CALCUL. A pas_in held high steps once every 2 cycles.
//  - Step rule: the step is evaluated on the positions p[] present at edge k+1.
//    Rotor 0 always advances.
//    Rotor i (1..NUM_ROTORI-1) advances if p[i-1]==notch[i-1].
//    Rotor i (1..NUM_ROTORI-2) also advances if p[i]==notch[i] (double step).
//    Every rotor advances by at most 1.
//  - Arithmetic: advancing from ALFABET-1 wraps to 0. No other value is ever stored.
//  - Load: scrie_in high in INACTIV with valid operands. At the next edge, position and notch
//    of rotor index_rotor_in are written; visible on pozitii_out in the following cycle.
//    Other rotors are untouched.
//  - Invalid load: any of index_rotor_in>=NUM_ROTORI, pozitie_initiala_in>=ALFABET,
//    crestatura_in>=ALFABET, or scrie_in while in CALCUL. No state change;
//    eroare_out=1 for exactly the next cycle.
//  - scrie_in and pas_in together in INACTIV: the load is performed (or rejected), the step
//    request is dropped, and no pas_gata_out is produced.
//  - Reset asserted during CALCUL: the step is abandoned, pas_gata_out is never produced,
//    and all state takes reset values.
// TESTING (NUM_ROTORI=3, ALFABET=26)
//  1. Assert rst mid-run -> pozitii_out=0 immediately (async); ocupat/pas_gata/eroare=0.
//  2. Load rotor1 pos 9 notch 4 -> pozitii_out[9:5]=9, other rotors 0, eroare_out stays 0.
//  3. notch0=16, notch1=4; p={16,3,0} (r0,r1,r2); pas_in -> {17,4,0};
//     next pas_in -> {18,5,1} (double step). pas_gata_out pulses 2 cycles after each request.
//  4. p0=25, notch0=25, p1=0 -> pas_in -> p0=0 (wrap), p1=1, p2=0.
//  5. Load index 3, then pos 26, then notch 30 -> three eroare_out pulses;
//     pozitii_out unchanged. scrie_in during CALCUL -> eroare_out pulse.
//  6. scrie_in+pas_in in the same cycle -> load applied, no step, no pas_gata_out;
//     rst raised during CALCUL -> positions 0, no pas_gata_out.

Source files
------------

// File: rtl/rotor_stack_stepper.sv
// rotor_stack_stepper
//   Keeps the position and notch of every rotor in a NUM_ROTORI-deep stack.
//   On each accepted key press the stack advances once, with the classic
//   carry and double-step rules. Initial positions and notches are loaded
//   one rotor at a time through a write port.
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   scrie_in                       load strobe for one rotor
//   index_rotor_in                 rotor to load
//   pozitie_initiala_in            position to load
//   crestatura_in                  notch to load
//   pas_in                         step request (one key press)
//   pozitii_out                    rotor i at [i*POS_W +: POS_W]
//   ocupat_out                     high while a step is being computed
//   pas_gata_out                   1-cycle pulse: new positions are valid
//   eroare_out                     1-cycle pulse: load was rejected
module rotor_stack_stepper #(
    parameter int NUM_ROTORI = 3,
    parameter int ALFABET    = 26,
    localparam int POS_W     = $clog2(ALFABET),
    localparam int SEL_W     = (NUM_ROTORI > 1) ? $clog2(NUM_ROTORI) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scrie_in,
    input  logic [SEL_W-1:0]            index_rotor_in,
    input  logic [POS_W-1:0]            pozitie_initiala_in,
    input  logic [POS_W-1:0]            crestatura_in,
    input  logic                        pas_in,
    output logic [NUM_ROTORI*POS_W-1:0] pozitii_out,
    output logic                        ocupat_out,
    output logic                        pas_gata_out,
    output logic                        eroare_out
);

    typedef enum logic {INACTIV = 1'b0, CALCUL = 1'b1} stare_t;

    localparam logic [POS_W-1:0] ULTIM = POS_W'(ALFABET - 1);

    stare_t                               stare_q, stare_d;
    logic [NUM_ROTORI-1:0][POS_W-1:0]     poz_q, poz_d;
    logic [NUM_ROTORI-1:0][POS_W-1:0]     notch_q, notch_d;
    logic [NUM_ROTORI-1:0][POS_W-1:0]     poz_pas;
    logic [NUM_ROTORI-1:0]                avans;
    logic                                 gata_q, gata_d;
    logic                                 err_q, err_d;
    logic                                 load_ok;

    // Per-rotor advance decision, taken from the positions held when the
    // step is committed (the CALCUL cycle).
    for (genvar g = 0; g < NUM_ROTORI; g++) begin : g_rotor
        if (g == 0) begin : g_rapid
            assign avans[g] = 1'b1;
        end else if (g < NUM_ROTORI - 1) begin : g_mijloc
            // Middle rotors also advance when sitting on their own notch
            // (double step).
            assign avans[g] = (poz_q[g-1] == notch_q[g-1]) || (poz_q[g] == notch_q[g]);
        end else begin : g_lent
            assign avans[g] = (poz_q[g-1] == notch_q[g-1]);
        end
        assign poz_pas[g] = !avans[g]          ? poz_q[g]
                          : (poz_q[g] == ULTIM) ? '0
                          :                       poz_q[g] + 1'b1;
    end

    assign load_ok = (int'(index_rotor_in) < NUM_ROTORI)
                  && (int'(pozitie_initiala_in) < ALFABET)
                  && (int'(crestatura_in) < ALFABET);

    always_comb begin
        stare_d = stare_q;
        poz_d   = poz_q;
        notch_d = notch_q;
        gata_d  = 1'b0;
        err_d   = 1'b0;
        case (stare_q)
            INACTIV: begin
                // A load wins over a simultaneous step request; the step is dropped.
                if (scrie_in) begin
                    if (load_ok) begin
                        for (int i = 0; i < NUM_ROTORI; i++) begin
                            if (int'(index_rotor_in) == i) begin
                                poz_d[i]   = pozitie_initiala_in;
                                notch_d[i] = crestatura_in;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (pas_in) begin
                    stare_d = CALCUL;
                end
            end
            CALCUL: begin
                poz_d   = poz_pas;
                gata_d  = 1'b1;
                stare_d = INACTIV;
                err_d   = scrie_in;
            end
            default: stare_d = INACTIV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stare_q <= INACTIV;
            poz_q   <= '0;
            notch_q <= {NUM_ROTORI{ULTIM}};
            gata_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stare_q <= stare_d;
            poz_q   <= poz_d;
            notch_q <= notch_d;
            gata_q  <= gata_d;
            err_q   <= err_d;
        end
    end

    assign pozitii_out  = poz_q;
    assign ocupat_out   = (stare_q == CALCUL);
    assign pas_gata_out = gata_q;
    assign eroare_out   = err_q;

endmodule
